// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and width helpers for the shared sqrt scheduler
package sqrt_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int STEP_W = 8;
   typedef logic [STEP_W-1:0] step_t;

   function automatic int root_w(input int n);
      return n / 2;
   endfunction

   function automatic int rem_w(input int n);
      return n / 2 + 2;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational non-restoring integer sqrt iteration
module sqrt_step
   import sqrt_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0]     a,
   input  logic [N/2-1:0]   q,
   input  logic [N/2+1:0]   r,
   output logic [N-1:0]     a_next,
   output logic [N/2-1:0]   q_next,
   output logic [N/2+1:0]   r_next
);

   localparam int QW = root_w(N);
   localparam int RW = rem_w(N);

   logic [RW-1:0] left;
   logic [RW-1:0] right;

   // sign of the running remainder selects add (restore) or subtract (trial)
   always_comb begin
      right  = {q, r[RW-1], 1'b1};
      left   = {r[QW-1:0], a[N-1:N-2]};
      r_next = r[RW-1] ? (left + right) : (left - right);
      q_next = {q[QW-2:0], ~r_next[RW-1]};
      a_next = {a[N-3:0], 2'b00};
   end

endmodule

// File: rtl/sqrt_sched.sv
// rtl/sqrt_sched.sv - round-robin scheduler sharing one iterative sqrt engine; SQRT_REMAINDER_EN adds resp_rem
module sqrt_sched
   import sqrt_pkg::*;
#(
   parameter int N    = 16,
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*N-1:0]    req_num,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [N/2-1:0]       resp_result,
   output logic [IDW-1:0]       resp_id,
`ifdef SQRT_REMAINDER_EN
   output logic [N/2:0]         resp_rem,
`endif
   output logic                 busy
);

   localparam int QW = root_w(N);
   localparam int RW = rem_w(N);

   if ((N % 2 != 0) || (N < 4) || (QW > 2 ** STEP_W)) begin : g_bad_n
      $error("sqrt_sched: N must be even, >= 4 and fit the step counter");
   end
   if (NREQ < 1) begin : g_bad_nreq
      $error("sqrt_sched: NREQ must be >= 1");
   end

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id;
   step_t           cnt;
   logic [N-1:0]    a;
   logic [QW-1:0]   q;
   logic [RW-1:0]   r;

   logic [N-1:0]    a_next;
   logic [QW-1:0]   q_next;
   logic [RW-1:0]   r_next;

   logic            found;
   logic [IDW-1:0]  gnt;
   logic [IDW-1:0]  ptr_inc;
   logic [IDW:0]    cand;
   logic [IDW:0]    nxt;
   logic [N-1:0]    sel_num;

   // rotating priority search starting at ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!found && req_valid[cand[IDW-1:0]]) begin
            found = 1'b1;
            gnt   = cand[IDW-1:0];
         end
      end
      nxt = {1'b0, gnt} + (IDW+1)'(1);
      if (nxt >= (IDW+1)'(NREQ)) nxt = '0;
      ptr_inc = nxt[IDW-1:0];
   end

   always_comb begin
      sel_num = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt == IDW'(k)) sel_num = req_num[k*N +: N];
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[gnt] = 1'b1;
   end

   sqrt_step #(.N(N)) u_step (
      .a      (a),
      .q      (q),
      .r      (r),
      .a_next (a_next),
      .q_next (q_next),
      .r_next (r_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         id         <= '0;
         cnt        <= '0;
         a          <= '0;
         q          <= '0;
         r          <= '0;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  a     <= sel_num;
                  id    <= gnt;
                  q     <= '0;
                  r     <= '0;
                  cnt   <= '0;
                  ptr   <= ptr_inc;
                  state <= CALC;
               end
            end
            CALC: begin
               a   <= a_next;
               q   <= q_next;
               r   <= r_next;
               cnt <= cnt + step_t'(1);
               if (cnt == step_t'(QW - 1)) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
`ifdef SQRT_REMAINDER_EN
                  // a negative final remainder is restored in the same edge
                  if (r_next[RW-1]) r <= r_next + RW'({q_next, 1'b1});
`endif
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign resp_result = q;
   assign resp_id     = id;
   assign busy        = (state != IDLE);
`ifdef SQRT_REMAINDER_EN
   assign resp_rem    = r[QW:0];
`endif

endmodule

// File: tb/tb_sqrt_sched.sv
// tb/tb_sqrt_sched.sv - scoreboard bench for sqrt_sched
module tb_sqrt_sched;

   localparam int N    = 16;
   localparam int NREQ = 2;
   localparam int IDW  = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              v0 = 1'b0, v1 = 1'b0;
   logic [N-1:0]      n0 = '0, n1 = '0;
   logic              resp_ready = 1'b0;
   wire  [NREQ-1:0]   req_valid = {v1, v0};
   wire  [NREQ*N-1:0] req_num   = {n1, n0};
   logic [NREQ-1:0]   req_ready;
   logic              resp_valid;
   logic [N/2-1:0]    resp_result;
   logic [IDW-1:0]    resp_id;
   logic              busy;
`ifdef SQRT_REMAINDER_EN
   logic [N/2:0]      resp_rem;
`endif

   typedef struct {int id; int num;} exp_t;
   exp_t sb[$];
   int   gl[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;

   sqrt_sched #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_num     (req_num),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_id     (resp_id),
`ifdef SQRT_REMAINDER_EN
      .resp_rem    (resp_rem),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic int isqrt(input int x);
      int s = 0;
      while ((s + 1) * (s + 1) <= x) s++;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (req_valid[0] && req_ready[0]) begin
            sb.push_back('{0, int'(n0)});
            gl.push_back(0);
         end
         if (req_valid[1] && req_ready[1]) begin
            sb.push_back('{1, int'(n1)});
            gl.push_back(1);
         end
         if (resp_valid && resp_ready) begin
            chk("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("resp_id", 32'(resp_id), mon_e.id);
               chk("resp_result", 32'(resp_result), isqrt(mon_e.num));
`ifdef SQRT_REMAINDER_EN
               chk("resp_rem", 32'(resp_rem), mon_e.num - isqrt(mon_e.num) * isqrt(mon_e.num));
`endif
            end
         end
      end
   end

   task automatic send(input int i, input int num);
      bit ok = 0;
      if (i == 0) begin v0 = 1'b1; n0 = N'(num); end
      else        begin v1 = 1'b1; n1 = N'(num); end
      #1;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (req_ready[i]) begin
            ok = 1;
            tick();
         end else begin
            tick();
            #1;
         end
      end
      if (i == 0) v0 = 1'b0; else v1 = 1'b0;
      if (!ok) chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         if (sb.size() == 0 && !busy && !resp_valid) ok = 1;
         else tick();
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic run_one(input int i, input int num, input int exp_res, input int exp_rem);
      int cnt = 0;
      resp_ready = 1'b1;
      send(i, num);
      while (!resp_valid && cnt < 50) begin
         tick();
         cnt++;
      end
      chk("latency", cnt, 8);
      chk("dir_result", 32'(resp_result), exp_res);
      chk("dir_id", 32'(resp_id), i);
`ifdef SQRT_REMAINDER_EN
      chk("dir_rem", 32'(resp_rem), exp_rem);
`else
      if (exp_rem < 0) chk("dir_rem_arg", 0, 1);
`endif
      wait_idle();
   endtask

   task automatic rnd_driver(input int i);
      int num;
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         case ($urandom_range(0, 7))
            0:       num = 0;
            1:       num = 65535;
            2:       num = 65025;
            default: num = $urandom_range(0, 65535);
         endcase
         send(i, num);
      end
      done_cnt++;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      bit seen;
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_result", 32'(resp_result), 0);
      chk("rst_resp_id", 32'(resp_id), 0);

      run_one(0, 144, 12, 0);
      run_one(1, 0, 0, 0);
      run_one(0, 65535, 255, 510);
      run_one(1, 65025, 255, 0);
      run_one(0, 3, 1, 2);

      // both requesters held valid from reset: grants must alternate
      rst = 1'b1;
      sb.delete();
      gl.delete();
      v0 = 1'b1; n0 = 16'd100;
      v1 = 1'b1; n1 = 16'd49;
      resp_ready = 1'b1;
      tick();
      rst = 1'b0;
      cnt = 0;
      while (gl.size() < 6 && cnt < 200) begin
         tick();
         cnt++;
      end
      v0 = 1'b0;
      v1 = 1'b0;
      wait_idle();
      for (int k = 0; k < 6; k++)
         chk("grant_order", (k < gl.size()) ? 32'(gl[k]) : 32'hffff_ffff, k % 2);

      // backpressure in DONE with a competing request pending
      resp_ready = 1'b0;
      send(1, 81);
      cnt = 0;
      while (!resp_valid && cnt < 50) begin
         tick();
         cnt++;
      end
      v0 = 1'b1;
      n0 = 16'd25;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_valid", 32'(resp_valid), 1);
         chk("bp_result", 32'(resp_result), 9);
         chk("bp_req_ready", 32'(req_ready), 0);
         chk("bp_busy", 32'(busy), 1);
      end
      resp_ready = 1'b1;
      tick();
      chk("rel_busy", 32'(busy), 0);
      chk("rel_valid", 32'(resp_valid), 0);
      chk("rel_req_ready", 32'(req_ready), 1);
      tick();
      chk("regrant_busy", 32'(busy), 1);
      v0 = 1'b0;
      wait_idle();

      // asynchronous reset in the middle of a calculation
      send(0, 400);
      repeat (3) tick();
      rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_valid", 32'(resp_valid), 0);
      chk("mid_rst_result", 32'(resp_result), 0);
      chk("mid_rst_id", 32'(resp_id), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ready", 32'(req_ready), 0);
      tick();
      tick();
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (resp_valid) seen = 1;
      end
      chk("no_ghost_resp", 32'(seen), 0);
      run_one(0, 400, 20, 0);

      // random traffic on both ports with random response backpressure
      done_cnt = 0;
      fork
         rnd_driver(0);
         rnd_driver(1);
         begin
            while (done_cnt < 2) begin
               resp_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
            resp_ready = 1'b1;
         end
      join
      wait_idle();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
